// File: rtl/step_motor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : step_motor_pkg
// Description : Shared types, phase table and step arithmetic for the
//               stepper sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package step_motor_pkg;

    typedef enum logic [1:0] {
        HALF = 2'd0,
        FULL = 2'd1,
        WAVE = 2'd2
    } mode_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [2:0] idx;
        logic [1:0] delta;
    } step_t;

    // Coil bits {A+, A-, B+, B-} for each of the eight half-step positions
    localparam logic [3:0] PHASE_TABLE [8] = '{
        4'b1000, 4'b1010, 4'b0010, 4'b0110,
        4'b0100, 4'b0101, 4'b0001, 4'b1001
    };

    function automatic mode_t decode_mode(input logic [1:0] raw);
        case (raw)
            2'd1:    return FULL;
            2'd2:    return WAVE;
            default: return HALF;
        endcase
    endfunction

    // Full-step parks on odd indices, wave on even; a misaligned index takes
    // a single half-step to realign, otherwise the move is two half-steps.
    function automatic step_t next_idx(input logic [2:0] idx, input logic dir,
                                       input mode_t mode);
        step_t      v_res;
        logic [1:0] v_mag;
        case (mode)
            FULL:    v_mag = idx[0] ? 2'd2 : 2'd1;
            WAVE:    v_mag = idx[0] ? 2'd1 : 2'd2;
            default: v_mag = 2'd1;
        endcase
        v_res.delta = v_mag;
        v_res.idx   = dir ? idx + {1'b0, v_mag} : idx - {1'b0, v_mag};
        return v_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/step_phase_seq.sv
`default_nettype none
// ============================================================================
// Module      : step_phase_seq
// Description : Phase index register and registered coil decode. With
//               STEP_MOTOR_POS_EN it also exports the signed step delta.
// Revision    : 1.0 - initial release
// ============================================================================
module step_phase_seq
    import step_motor_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  en,
    input  logic  step,
    input  logic  dir,
    input  mode_t mode,
    output logic  coil_a_p,
    output logic  coil_a_n,
    output logic  coil_b_p,
    output logic  coil_b_n
`ifdef STEP_MOTOR_POS_EN
    ,
    output logic signed [2:0] step_delta
`endif
);

    logic [2:0] r_idx;
    logic [3:0] r_coils;
    step_t      w_nxt;
    logic [2:0] w_idx_next;

    always_comb begin
        w_nxt      = next_idx(r_idx, dir, mode);
        w_idx_next = step ? w_nxt.idx : r_idx;
    end

    // Coils track the index being written this edge, so they move with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= 3'd0;
            r_coils <= 4'b0000;
        end else begin
            r_idx   <= w_idx_next;
            r_coils <= en ? PHASE_TABLE[w_idx_next] : 4'b0000;
        end
    end

    assign {coil_a_p, coil_a_n, coil_b_p, coil_b_n} = r_coils;

`ifdef STEP_MOTOR_POS_EN
    assign step_delta = dir ? $signed({1'b0, w_nxt.delta})
                            : -$signed({1'b0, w_nxt.delta});
`else
    logic w_unused_delta;
    assign w_unused_delta = ^w_nxt.delta;
`endif

endmodule
`default_nettype wire

// File: rtl/step_motor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : step_motor_ctrl
// Description : Counted-move stepper sequencer with rate divider, pause and
//               abort. Define STEP_MOTOR_POS_EN to add the position counter.
// Revision    : 1.0 - initial release
// ============================================================================
module step_motor_ctrl
    import step_motor_pkg::*;
#(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
`ifdef STEP_MOTOR_POS_EN
    ,
    parameter int POS_W = 32
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [CNT_W-1:0] cmd_steps,
    input  logic             cmd_dir,
    input  logic [1:0]       cmd_mode,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             coil_a_p,
    output logic             coil_a_n,
    output logic             coil_b_p,
    output logic             coil_b_n
`ifdef STEP_MOTOR_POS_EN
    ,
    input  logic                    pos_clr,
    output logic signed [POS_W-1:0] pos
`endif
);

    localparam logic [0:0] C_ST_IDLE = 1'(IDLE);
    localparam logic [0:0] C_ST_RUN  = 1'(RUN);

    logic [0:0]       r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_rem;
    logic             r_dir;
    mode_t            r_mode;
    logic             r_done;

    logic w_run;
    logic w_accept;
    logic w_step;

    assign w_run     = (r_state == C_ST_RUN);
    assign cmd_ready = (r_state == C_ST_IDLE) && !abort;
    assign w_accept  = cmd_valid && cmd_ready;
    // Abort takes priority over a step falling due on the same edge
    assign w_step    = w_run && en && !abort && (r_cnt == '0);
    assign busy      = w_run;
    assign done      = r_done;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
            r_cnt   <= '0;
            r_div   <= '0;
            r_rem   <= '0;
            r_dir   <= 1'b0;
            r_mode  <= HALF;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                C_ST_IDLE: begin
                    if (w_accept) begin
                        r_dir  <= cmd_dir;
                        r_mode <= decode_mode(cmd_mode);
                        r_div  <= cmd_div;
                        r_cnt  <= cmd_div;
                        r_rem  <= cmd_steps;
                        if (cmd_steps == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= C_ST_RUN;
                        end
                    end
                end
                default: begin
                    if (abort) begin
                        r_state <= C_ST_IDLE;
                    end else if (en) begin
                        if (r_cnt == '0) begin
                            r_cnt <= r_div;
                            r_rem <= r_rem - 1'b1;
                            if (r_rem == CNT_W'(1)) begin
                                r_state <= C_ST_IDLE;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                end
            endcase
        end
    end

`ifdef STEP_MOTOR_POS_EN
    logic signed [2:0]       w_step_delta;
    logic signed [POS_W-1:0] w_pos_inc;
    logic signed [POS_W-1:0] r_pos;

    assign w_pos_inc = w_step ? {{(POS_W-3){w_step_delta[2]}}, w_step_delta} : '0;

    // A clear coinciding with a step leaves just that step's delta
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pos <= '0;
        end else if (pos_clr || w_step) begin
            r_pos <= (pos_clr ? '0 : r_pos) + w_pos_inc;
        end
    end

    assign pos = r_pos;
`endif

    step_phase_seq u_seq (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .step       (w_step),
        .dir        (r_dir),
        .mode       (r_mode),
        .coil_a_p   (coil_a_p),
        .coil_a_n   (coil_a_n),
        .coil_b_p   (coil_b_p),
        .coil_b_n   (coil_b_n)
`ifdef STEP_MOTOR_POS_EN
        ,
        .step_delta (w_step_delta)
`endif
    );

endmodule
`default_nettype wire

// File: tb/tb_step_motor_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_step_motor_ctrl
// Description : Scoreboard bench for step_motor_ctrl; define STEP_MOTOR_POS_EN
//               to include the position counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_step_motor_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_steps = '0;
    logic        cmd_dir = 1'b0;
    logic [1:0]  cmd_mode = '0;
    logic [15:0] cmd_div = '0;
    logic        abort = 1'b0;
    logic        cmd_ready, busy, done;
    logic        coil_a_p, coil_a_n, coil_b_p, coil_b_n;
    logic        pos_clr = 1'b0;
    logic signed [31:0] pos_v;

    step_motor_ctrl #(.DIV_W(16), .CNT_W(16)
`ifdef STEP_MOTOR_POS_EN
        , .POS_W(32)
`endif
    ) dut (
        .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_steps(cmd_steps), .cmd_dir(cmd_dir), .cmd_mode(cmd_mode), .cmd_div(cmd_div),
        .abort(abort), .busy(busy), .done(done),
        .coil_a_p(coil_a_p), .coil_a_n(coil_a_n), .coil_b_p(coil_b_p), .coil_b_n(coil_b_n)
`ifdef STEP_MOTOR_POS_EN
        , .pos_clr(pos_clr), .pos(pos_v)
`endif
    );

`ifndef STEP_MOTOR_POS_EN
    assign pos_v = '0;
`endif

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit noise = 1'b0;
    bit mon_off = 1'b0;

    typedef struct {
        int          cyc;
        logic [37:0] val;
    } ev_t;
    ev_t exp_q[$];

    logic [3:0] tbl [8] = '{4'b1000, 4'b1010, 4'b0010, 4'b0110,
                            4'b0100, 4'b0101, 4'b0001, 4'b1001};

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [37:0] dut_out();
        return {coil_a_p, coil_a_n, coil_b_p, coil_b_n, busy, done, pos_v};
    endfunction

    // ---------------- reference model: move described in whole steps ----------
    int          m_busy, m_left, m_wait, m_idx, m_mode, m_div, m_dir, m_mv;
    bit          m_done, m_stp;
    logic [3:0]  m_coils;
    logic signed [31:0] m_pos;
    logic [37:0] m_prev, m_val;

    // Walk half-steps until the index lands on the mode's resting parity
    function automatic void ref_step(input int mode, input int dir, inout int idx, output int moved);
        moved = 0;
        do begin
            idx = dir != 0 ? (idx + 1) % 8 : (idx + 7) % 8;
            moved++;
        end while ((mode == 1 && idx % 2 == 0) || (mode == 2 && idx % 2 == 1));
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_busy = 0; m_idx = 0; m_pos = '0; m_prev = '0;
        end else begin
            m_done = 1'b0;
            m_stp  = 1'b0;
            m_mv   = 0;
            if (m_busy == 0) begin
                if (cmd_valid && !abort) begin
                    m_dir  = int'(cmd_dir);
                    m_mode = (cmd_mode == 2'd3) ? 0 : int'(cmd_mode);
                    m_div  = int'(cmd_div);
                    if (cmd_steps == 0) m_done = 1'b1;
                    else begin
                        m_busy = 1; m_left = int'(cmd_steps); m_wait = m_div + 1;
                    end
                end
            end else if (abort) begin
                m_busy = 0;
            end else if (en) begin
                m_wait--;
                if (m_wait == 0) begin
                    ref_step(m_mode, m_dir, m_idx, m_mv);
                    m_stp = 1'b1;
                    m_left--;
                    m_wait = m_div + 1;
                    if (m_left == 0) begin m_busy = 0; m_done = 1'b1; end
                end
            end
            m_coils = en ? tbl[m_idx] : 4'b0000;
`ifdef STEP_MOTOR_POS_EN
            if (pos_clr) m_pos = '0;
            if (m_stp) m_pos = m_dir != 0 ? m_pos + m_mv : m_pos - m_mv;
`endif
            m_val = {m_coils, m_busy[0], m_done, m_pos};
            if (m_val !== m_prev) exp_q.push_back('{cyc, m_val});
            m_prev = m_val;
        end
    end

    // ---------------- monitor: compare every visible output change ----------
    logic [37:0] mon_prev = '0;
    logic [37:0] mon_cur;
    ev_t         mon_e;

    always @(negedge clk) begin
        if (rst) begin
            mon_prev = '0;
        end else if (!mon_off) begin
            mon_cur = dut_out();
            if (mon_cur !== mon_prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_change: got %0h expected no change cyc=%0d", mon_cur, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.cyc != cyc || mon_e.val !== mon_cur) begin
                        failures++;
                        $display("FAIL output_event: got %0h at cyc %0d expected %0h at cyc %0d",
                                 mon_cur, cyc, mon_e.val, mon_e.cyc);
                    end
                end
                mon_prev = mon_cur;
            end
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                mon_e = exp_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missing_event: got %0h expected %0h at cyc %0d", mon_cur, mon_e.val, mon_e.cyc);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
        if (noise) begin
            en    = ($urandom_range(0, 7) != 0);
            abort = ($urandom_range(0, 39) == 0);
`ifdef STEP_MOTOR_POS_EN
            pos_clr = ($urandom_range(0, 29) == 0);
`endif
        end
    endtask

    task automatic send(input int steps, input bit dir, input int mode, input int div);
        int n = 0;
        tick();
        cmd_valid = 1'b1;
        cmd_steps = 16'(steps);
        cmd_dir   = dir;
        cmd_mode  = 2'(mode);
        cmd_div   = 16'(div);
        #1;
        while (!cmd_ready) begin
            n++;
            if (n > 300) begin
                chk("handshake_timeout", 64'(n), 64'd0);
                break;
            end
            tick();
            #1;
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        #1;
        while (busy) begin
            n++;
            if (n > 3000) begin
                chk("busy_timeout", 64'(n), 64'd0);
                break;
            end
            tick();
            #1;
        end
        tick();
        tick();
    endtask

    task automatic coils_is(input string name, input logic [3:0] exp);
        chk(name, 64'({coil_a_p, coil_a_n, coil_b_p, coil_b_n}), 64'(exp));
    endtask

    initial begin
        tick(); tick();
        #1;
        coils_is("reset_coils", 4'b0000);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        tick();
        rst = 1'b0;
        #1;
        chk("ready_after_reset", 64'(cmd_ready), 64'd1);
        en = 1'b1;
        tick();

        // half-step forward, 10 steps every 4 cycles -> idx 2
        send(10, 1'b1, 0, 3);
        wait_idle();
        coils_is("half_fwd_end", 4'b0010);

        // back to idx 0, then full-step reverse 3 -> idx 7,5,3
        send(2, 1'b0, 0, 0);
        wait_idle();
        send(3, 1'b0, 1, 0);
        wait_idle();
        coils_is("full_rev_end", 4'b0110);

        // to idx 1, then wave forward 4 -> idx 2,4,6,0
        send(2, 1'b0, 0, 0);
        wait_idle();
        send(4, 1'b1, 2, 1);
        wait_idle();
        coils_is("wave_fwd_end", 4'b1000);

        // pause with en low for 7 cycles mid-move
        send(20, 1'b1, 0, 1);
        repeat (10) tick();
        en = 1'b0;
        tick();
        #1;
        coils_is("en_low_coils", 4'b0000);
        chk("en_low_busy", 64'(busy), 64'd1);
        repeat (6) tick();
        en = 1'b1;
        wait_idle();
        coils_is("pause_resume_end", 4'b0100);

        // abort on step 5 of 20 -> idx 1, coils held
        send(20, 1'b1, 0, 0);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        coils_is("abort_hold", 4'b1010);
        tick();

        // abort in IDLE blocks acceptance
        cmd_valid = 1'b1; cmd_steps = 16'd5; abort = 1'b1;
        #1;
        chk("abort_idle_ready", 64'(cmd_ready), 64'd0);
        tick();
        cmd_valid = 1'b0; abort = 1'b0;
        tick();

        // zero-step command, then a command ignored while busy
        send(0, 1'b1, 0, 0);
        tick();
        send(7, 1'b1, 0, 2);
        tick();
        cmd_valid = 1'b1; cmd_steps = 16'd3; cmd_dir = 1'b0; cmd_mode = 2'd1;
        #1;
        chk("busy_ready", 64'(cmd_ready), 64'd0);
        repeat (3) tick();
        cmd_valid = 1'b0;
        wait_idle();
        coils_is("ignored_cmd_end", 4'b1000);

        // full-step forward 4 from idx 0 -> idx 7, position +7
        pos_clr = 1'b1;
        tick();
        pos_clr = 1'b0;
        send(4, 1'b1, 1, 0);
        wait_idle();
        coils_is("full_fwd_end", 4'b1001);
`ifdef STEP_MOTOR_POS_EN
        chk("pos_full_fwd", 64'(pos_v), 64'(32'sd7));
`endif

        // randomized moves with en/abort noise
        noise = 1'b1;
        for (int i = 0; i < 25; i++) begin
            send(int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            wait_idle();
        end
        noise = 1'b0;
        en = 1'b1; abort = 1'b0; pos_clr = 1'b0;
        tick(); tick();

        // asynchronous reset in the middle of a move
        send(30, 1'b1, 0, 0);
        repeat (4) tick();
        #1;
        chk("busy_before_rst", 64'(busy), 64'd1);
        mon_off = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        coils_is("async_rst_coils", 4'b0000);
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_done", 64'(done), 64'd0);
        chk("async_rst_pos", 64'(pos_v), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
